apu_access_arbiter: RTL and testbench
=====================================

Name: apu_access_arbiter

Overview:
- Shares one access-protection lookup unit (APU) between NUM_REQ requesters on the NoC security path.
- Grants requests round-robin and drives the latched address to the APU. It samples the 2-bit permission, then either forwards the access downstream or rejects it with an error pulse.
- Keeps a saturating violation counter and a sticky interrupt for the security monitor.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
CNT_W, 16, violation counter width
ID_W, 3, requester index width (must satisfy 2^ID_W >= NUM_REQ)

Ports:
ACLK  in  1  clock, all state on rising edge
ARESET  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_write  in  NUM_REQ  1 = write access, 0 = read access
req_ready  out  NUM_REQ  one-hot accept strobe
apu_addr  out  ADDR_W  address presented to the APU
apu_perm  in  2  APU result: 00 open, 01 read-protected, 10 write-protected, 11 deny all
m_valid  out  1  downstream access valid
m_ready  in  1  downstream accept
m_addr  out  ADDR_W  forwarded address
m_write  out  1  forwarded direction
m_id  out  ID_W  originating requester
err_valid  out  1  one-cycle denial pulse
err_id  out  ID_W  denied requester
err_perm  out  2  permission that caused the denial
enforce  in  1  1 = block violations; 0 = log only, forward anyway
viol_cnt  out  CNT_W  saturating violation count
viol_irq  out  1  sticky violation flag
irq_clr  in  1  clears viol_irq

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0, m_valid=0, err_valid=0.
  - m_addr, apu_addr, m_id, err_id, err_perm, m_write = 0.
  - viol_cnt=0, viol_irq=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has priority first.
- FSM states: IDLE, LOOKUP, FWD, DENY.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from last+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; all other bits are 0.
  - On the edge: capture addr, write and g; set last=g; go to LOOKUP.
  - No request pending: stay in IDLE, req_ready=0.
- LOOKUP (1 cycle):
  - apu_addr holds the captured address; it is registered and stable through LOOKUP.
  - apu_perm is sampled at the end of LOOKUP.
- Violation rule:
  - Read violation: perm 01 or 11.
  - Write violation: perm 10 or 11.
- Next state after LOOKUP:
  - No violation: FWD.
  - Violation and enforce=1: DENY.
  - Violation and enforce=0: FWD, and the violation is still logged in the same cycle as the transition.
- FWD:
  - m_valid=1 with m_addr, m_write, m_id stable until m_valid&m_ready.
  - After the handshake, return to IDLE.
  - m_ready has no effect outside FWD.
- DENY:
  - err_valid=1 for exactly one cycle, with err_id and err_perm.
  - Then IDLE.
- Latency: accept at cycle T; m_valid or err_valid first high at T+2. Best-case throughput is one access per 3 cycles.
- Logging:
  - Each violation increments viol_cnt by 1, saturating at all-ones with no wrap.
  - Each violation sets viol_irq.
  - irq_clr clears viol_irq. If irq_clr coincides with a new violation, set wins.
- enforce is sampled only at the end of LOOKUP. Changes during FWD or DENY do not affect the transaction in flight.
- A requester dropping req_valid while not granted has no effect. Requests are never aborted once accepted.
- ARESET mid-operation: every register returns to its reset value immediately, the in-flight access is discarded, and m_valid/err_valid drop without a handshake.

Test Plan:
- Single request, open region: req 0 valid, addr 0x0000_1000, write, apu_perm=00, m_ready=1 -> req_ready=0001 at T, m_valid at T+2 with m_id=0, m_addr=0x0000_1000, m_write=1; no err, viol_cnt=0.
- Round-robin fairness: req_valid=1111 held, perm 00, m_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles; m_id follows the same sequence.
- Write to write-protected region: req 2 write, perm=10, enforce=1 -> err_valid for 1 cycle at T+2, err_id=2, err_perm=10, m_valid never high, viol_cnt=1, viol_irq=1. Repeat as a read with perm=10 -> forwarded, no count.
- Log-only mode: enforce=0, read with perm=01 -> m_valid at T+2 (forwarded), viol_cnt increments, viol_irq=1. Then irq_clr=1 in the same cycle as another violation -> viol_irq stays 1. irq_clr alone -> 0.
- Backpressure: m_ready=0 for 5 cycles -> m_valid, m_addr, m_id held stable; req_ready stays 0 for all requesters until the handshake; next grant in the cycle after the handshake.
- Saturation and reset: CNT_W=4, 17 violations -> viol_cnt=15. Assert ARESET during FWD -> m_valid=0 asynchronously, viol_cnt=0, next grant goes to req 0.

Source files
------------

// File: rtl/apu_access_arbiter.sv
// Round-robin arbiter sharing one access-protection lookup unit between NUM_REQ requesters.
// Each accepted access is checked against the APU permission, then forwarded downstream or rejected.
module apu_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int ID_W    = 3
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         apu_addr,
  input  logic [1:0]                apu_perm,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_write,
  output logic [ID_W-1:0]           m_id,
  output logic                      err_valid,
  output logic [ID_W-1:0]           err_id,
  output logic [1:0]                err_perm,
  input  logic                      enforce,
  output logic [CNT_W-1:0]          viol_cnt,
  output logic                      viol_irq,
  input  logic                      irq_clr
);

  typedef enum logic [1:0] {IDLE, LOOKUP, FWD, DENY} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [1:0]          perm_q, perm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                irq_q, irq_d;

  logic [ID_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_vld;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                gnt_write;
  logic                is_viol;
  logic                log_viol;

  // Candidate gi is the requester gi+1 places after the last grant, wrapped modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum           = {1'b0, last_q} + (ID_W+1)'(gi + 1);
    assign cand_idx[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                        : sum[ID_W-1:0];
    assign cand_vld[gi]  = |(req_valid & (NUM_REQ'(1) << cand_idx[gi]));
    assign gnt_oh[gi]    = gnt_found && (gnt_idx == ID_W'(gi));
    assign req_ready[gi] = (state_q == IDLE) && gnt_oh[gi];
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && cand_vld[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    gnt_addr  = '0;
    gnt_write = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) begin
        gnt_addr  = req_addr[k*ADDR_W +: ADDR_W];
        gnt_write = req_write[k];
      end
    end
  end

  // perm bit 1 blocks writes, bit 0 blocks reads; 11 blocks both.
  assign is_viol = write_q ? apu_perm[1] : apu_perm[0];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    addr_d   = addr_q;
    write_d  = write_q;
    perm_d   = perm_q;
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    log_viol = 1'b0;
    if (irq_clr) irq_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = LOOKUP;
          last_d  = gnt_idx;
          id_d    = gnt_idx;
          addr_d  = gnt_addr;
          write_d = gnt_write;
        end
      end
      LOOKUP: begin
        perm_d   = apu_perm;
        log_viol = is_viol;
        state_d  = (is_viol && enforce) ? DENY : FWD;
      end
      FWD:     if (m_ready) state_d = IDLE;
      DENY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A violation logged this cycle overrides a simultaneous clear.
    if (log_viol) begin
      irq_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      perm_q  <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      perm_q  <= perm_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign apu_addr  = addr_q;
  assign m_addr    = addr_q;
  assign m_write   = write_q;
  assign m_id      = id_q;
  assign m_valid   = (state_q == FWD);
  assign err_valid = (state_q == DENY);
  assign err_id    = id_q;
  assign err_perm  = perm_q;
  assign viol_cnt  = cnt_q;
  assign viol_irq  = irq_q;

endmodule

// File: tb/tb_apu_access_arbiter.sv
// Self-checking bench for apu_access_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_apu_access_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam int IW = 3;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_write = '0;
  logic [NR-1:0]   req_ready;
  logic [AW-1:0]   apu_addr;
  logic [1:0]      apu_perm = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [AW-1:0]   m_addr;
  logic            m_write;
  logic [IW-1:0]   m_id;
  logic            err_valid;
  logic [IW-1:0]   err_id;
  logic [1:0]      err_perm;
  logic            enforce = 1'b1;
  logic [CW-1:0]   viol_cnt;
  logic            viol_irq;
  logic            irq_clr = 1'b0;

  logic [AW-1:0]   a_arr [NR];
  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  always_comb begin
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = a_arr[i];
  end

  apu_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .CNT_W(CW), .ID_W(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_ready(req_ready),
    .apu_addr(apu_addr), .apu_perm(apu_perm),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_write(m_write), .m_id(m_id),
    .err_valid(err_valid), .err_id(err_id), .err_perm(err_perm),
    .enforce(enforce), .viol_cnt(viol_cnt), .viol_irq(viol_irq), .irq_clr(irq_clr)
  );

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; apu_perm = '0; m_ready = 1'b0; enforce = 1'b1; irq_clr = 1'b0;
    for (int i = 0; i < NR; i++) a_arr[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    clear_inputs();
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESET = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    total++; if ({m_valid, err_valid} !== 2'b00) begin bad++; $display("FAIL rst_valids: got %b want 00", {m_valid, err_valid}); end
    total++; if (m_addr !== 32'h0 || apu_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h/%h want 0", m_addr, apu_addr); end
    total++; if ({m_id, err_id, err_perm, m_write} !== 9'h0) begin bad++; $display("FAIL rst_fields: got %h want 0", {m_id, err_id, err_perm, m_write}); end
    total++; if ({viol_cnt, viol_irq} !== 5'h0) begin bad++; $display("FAIL rst_log: got %h want 0", {viol_cnt, viol_irq}); end
    @(negedge ACLK);
    ARESET = 1'b0;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_open();
    do_reset();
    req_valid = 4'b0001; a_arr[0] = 32'h0000_1000; req_write = 4'b0001; m_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    @(negedge ACLK);
    req_valid = '0;
    #1;
    total++; if (apu_addr !== 32'h0000_1000 || m_valid !== 1'b0) begin bad++; $display("FAIL single_lookup: got addr=%h mv=%b want 00001000/0", apu_addr, m_valid); end
    @(negedge ACLK);
    total++; if ({m_valid, m_id, m_write, err_valid} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL single_fwd: got mv=%b id=%0d w=%b ev=%b want 1/0/1/0", m_valid, m_id, m_write, err_valid); end
    total++; if (m_addr !== 32'h0000_1000 || viol_cnt !== 4'd0) begin bad++; $display("FAIL single_data: got addr=%h cnt=%0d want 00001000/0", m_addr, viol_cnt); end
    @(negedge ACLK);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_done: got mv=%b want 0", m_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NR; i++) a_arr[i] = 32'hA0 + 32'h100 * i;
    req_valid = 4'b1111; m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (req_ready !== 4'(1 << (k % NR))) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % NR))); end
      @(negedge ACLK);
      @(negedge ACLK);
      total++; if (m_valid !== 1'b1 || m_id !== IW'(k % NR) || m_addr !== 32'hA0 + 32'h100 * (k % NR)) begin
        bad++; $display("FAIL rr_fwd%0d: got mv=%b id=%0d addr=%h want 1/%0d", k, m_valid, m_id, m_addr, k % NR); end
      @(negedge ACLK);
    end
    req_valid = '0;
  endtask

  task automatic test_deny();
    do_reset();
    enforce = 1'b1; apu_perm = 2'b10; req_valid = 4'b0100; req_write = 4'b0100; a_arr[2] = 32'h2000; m_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL deny_grant: got %b want 0100", req_ready); end
    @(negedge ACLK); req_valid = '0;
    @(negedge ACLK);
    total++; if ({err_valid, m_valid, err_id, err_perm} !== {1'b1, 1'b0, 3'd2, 2'b10}) begin bad++; $display("FAIL deny_err: got ev=%b mv=%b id=%0d perm=%b want 1/0/2/10", err_valid, m_valid, err_id, err_perm); end
    @(negedge ACLK);
    total++; if ({err_valid, m_valid} !== 2'b00) begin bad++; $display("FAIL deny_pulse: got %b want 00", {err_valid, m_valid}); end
    total++; if (viol_cnt !== 4'd1 || viol_irq !== 1'b1) begin bad++; $display("FAIL deny_log: got cnt=%0d irq=%b want 1/1", viol_cnt, viol_irq); end
    req_valid = 4'b0100; req_write = 4'b0000;
    @(negedge ACLK); req_valid = '0;
    @(negedge ACLK);
    total++; if ({m_valid, err_valid, m_id} !== {1'b1, 1'b0, 3'd2}) begin bad++; $display("FAIL deny_read_fwd: got mv=%b ev=%b id=%0d want 1/0/2", m_valid, err_valid, m_id); end
    @(negedge ACLK);
    total++; if (viol_cnt !== 4'd1) begin bad++; $display("FAIL deny_read_cnt: got %0d want 1", viol_cnt); end
  endtask

  task automatic test_log_only();
    do_reset();
    enforce = 1'b0; apu_perm = 2'b01; req_valid = 4'b0010; a_arr[1] = 32'h3000; m_ready = 1'b1;
    @(negedge ACLK); req_valid = '0;
    @(negedge ACLK);
    total++; if ({m_valid, err_valid, viol_cnt, viol_irq} !== {1'b1, 1'b0, 4'd1, 1'b1}) begin bad++; $display("FAIL log_fwd: got mv=%b ev=%b cnt=%0d irq=%b want 1/0/1/1", m_valid, err_valid, viol_cnt, viol_irq); end
    @(negedge ACLK); req_valid = 4'b0010;
    @(negedge ACLK); req_valid = '0; irq_clr = 1'b1;
    @(negedge ACLK); irq_clr = 1'b0;
    total++; if (viol_irq !== 1'b1 || viol_cnt !== 4'd2) begin bad++; $display("FAIL log_set_wins: got irq=%b cnt=%0d want 1/2", viol_irq, viol_cnt); end
    @(negedge ACLK); irq_clr = 1'b1;
    @(negedge ACLK); irq_clr = 1'b0;
    total++; if (viol_irq !== 1'b0) begin bad++; $display("FAIL log_clear: got %b want 0", viol_irq); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b1000; a_arr[3] = 32'hDEAD_BEEF; m_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    @(negedge ACLK); req_valid = 4'b1111;
    @(negedge ACLK);
    for (int c = 0; c < 5; c++) begin
      total++; if ({m_valid, m_id, m_addr, req_ready} !== {1'b1, 3'd3, 32'hDEAD_BEEF, 4'b0000}) begin
        bad++; $display("FAIL bp_hold%0d: got mv=%b id=%0d addr=%h rr=%b want 1/3/deadbeef/0000", c, m_valid, m_id, m_addr, req_ready); end
      @(negedge ACLK);
    end
    m_ready = 1'b1;
    #1;
    total++; if (m_valid !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hs: got mv=%b rr=%b want 1/0000", m_valid, req_ready); end
    @(negedge ACLK);
    total++; if (m_valid !== 1'b0 || req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next: got mv=%b rr=%b want 0/0001", m_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_saturation_reset();
    do_reset();
    enforce = 1'b1; apu_perm = 2'b11; req_valid = 4'b0001; m_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL sat_grant%0d: got %b want 0001", k, req_ready); end
      repeat (3) @(negedge ACLK);
    end
    req_valid = '0;
    #1;
    total++; if (viol_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt: got %0d want 15", viol_cnt); end
    apu_perm = 2'b00; req_valid = 4'b0010; m_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL sat_rr_after: got %b want 0010", req_ready); end
    @(negedge ACLK); req_valid = '0;
    @(negedge ACLK);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL sat_in_fwd: got %b want 1", m_valid); end
    ARESET = 1'b1;
    #1;
    total++; if ({m_valid, err_valid, viol_cnt, viol_irq} !== 7'h0) begin bad++; $display("FAIL async_rst: got mv=%b ev=%b cnt=%0d irq=%b want 0", m_valid, err_valid, viol_cnt, viol_irq); end
    @(negedge ACLK);
    ARESET = 1'b0; req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_regrant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int m_last, m_cnt, c_id, g, idx;
    bit m_busy, m_lookup, m_deny, m_irq, c_write, viol_now;
    logic [AW-1:0] c_addr;
    logic [1:0] c_perm;
    logic [NR-1:0] exp_rr;
    logic [79:0] exp_bus, obs_bus;
    do_reset();
    m_last = NR - 1; m_cnt = 0; c_id = 0; m_busy = 0; m_lookup = 0; m_deny = 0; m_irq = 0;
    c_write = 0; c_addr = '0; c_perm = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = NR'($urandom_range(0, 15));
      req_write = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) a_arr[i] = $urandom;
      apu_perm = 2'($urandom_range(0, 3));
      enforce  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 9) < 6);
      irq_clr  = ($urandom_range(0, 9) == 0);
      #1;
      g = -1;
      if (!m_busy) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rr = '0;
      if (g >= 0) exp_rr[g] = 1'b1;
      exp_bus = {m_busy && !m_lookup && !m_deny, m_busy && !m_lookup && m_deny, c_write,
                 IW'(c_id), IW'(c_id), c_perm, c_addr, c_addr, CW'(m_cnt), m_irq};
      obs_bus = {m_valid, err_valid, m_write, m_id, err_id, err_perm, m_addr, apu_addr, viol_cnt, viol_irq};
      total++; if (req_ready !== exp_rr) begin bad++; $display("FAIL rand_rr@%0d: got %b want %b", cyc, req_ready, exp_rr); end
      total++; if (obs_bus !== exp_bus) begin bad++; $display("FAIL rand_out@%0d: got %h want %h", cyc, obs_bus, exp_bus); end
      @(posedge ACLK);
      viol_now = 0;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_lookup = 1; m_last = g; c_id = g;
          c_addr = a_arr[g]; c_write = req_write[g];
        end
      end else if (m_lookup) begin
        c_perm = apu_perm;
        viol_now = (apu_perm == 2'b11) || (c_write && apu_perm == 2'b10) || (!c_write && apu_perm == 2'b01);
        m_deny = viol_now && enforce;
        m_lookup = 0;
      end else if (m_deny) begin
        m_busy = 0; m_deny = 0;
        $display("txn deny id=%0d addr=%h perm=%b", c_id, c_addr, c_perm);
      end else if (m_ready) begin
        m_busy = 0;
        $display("txn fwd  id=%0d addr=%h write=%b", c_id, c_addr, c_write);
      end
      if (viol_now) begin
        m_irq = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else if (irq_clr) begin
        m_irq = 0;
      end
      @(negedge ACLK);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_open();
    test_round_robin();
    test_deny();
    test_log_only();
    test_backpressure();
    test_saturation_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
